// File: rtl/img_lk_accumulator_if.sv
// Frame-sum handshake bundle between the LK accumulator and the flow solver.
// m_saturated exists only when IMG_LK_ACCUMULATOR_SATURATE_EN is defined.
interface img_lk_accumulator_if #(
   parameter int ACC_BITS   = 48,
   parameter int COUNT_BITS = 24
);
   logic                       m_valid;
   logic                       m_ready;
   logic signed [ACC_BITS-1:0] m_gxx;
   logic signed [ACC_BITS-1:0] m_gyy;
   logic signed [ACC_BITS-1:0] m_gxy;
   logic signed [ACC_BITS-1:0] m_ex;
   logic signed [ACC_BITS-1:0] m_ey;
   logic [COUNT_BITS-1:0]      m_count;
   logic                       m_overrun;
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
   logic                       m_saturated;
`endif

   modport master (
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
      output m_saturated,
`endif
      output m_valid, m_gxx, m_gyy, m_gxy,
      output m_ex, m_ey, m_count, m_overrun,
      input  m_ready
   );

   modport slave (
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
      input  m_saturated,
`endif
      input  m_valid, m_gxx, m_gyy, m_gxy,
      input  m_ex, m_ey, m_count, m_overrun,
      output m_ready
   );
endinterface

// File: rtl/img_lk_accumulator.sv
// Lucas-Kanade product accumulator: per-frame sums of the five LK products.
// Optional macro IMG_LK_ACCUMULATOR_SATURATE_EN: saturating sums, m_saturated.
module img_lk_accumulator #(
   parameter int SOBEL_BITS = 12,
   parameter int ACC_BITS   = 48,
   parameter int COUNT_BITS = 24
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         cke,
   input  logic                         s_valid,
   input  logic                         s_first,
   input  logic                         s_last,
   input  logic signed [SOBEL_BITS-1:0] s_diff,
   input  logic signed [SOBEL_BITS-1:0] s_gradx,
   input  logic signed [SOBEL_BITS-1:0] s_grady,
   img_lk_accumulator_if.master         m
);
   localparam int PW = 2 * SOBEL_BITS;
   localparam int NS = 5;
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
   localparam int SW = ((ACC_BITS > PW) ? ACC_BITS : PW) + 1;
   localparam logic [ACC_BITS-1:0] SAT_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
   localparam logic [ACC_BITS-1:0] SAT_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
`else
   localparam int SW = ACC_BITS;
`endif

   typedef enum logic {ST_IDLE, ST_ACC} state_t;

   state_t                state_q, state_d;

   logic signed [PW-1:0]  gx_w, gy_w, dt_w;
   logic                  pv_q, pf_q, pl_q;
   logic signed [PW-1:0]  prod_q [NS];

   logic [ACC_BITS-1:0]   acc_q [NS];
   logic [ACC_BITS-1:0]   acc_d [NS];
   logic [COUNT_BITS-1:0] cnt_q, cnt_d;
   logic                  done_q, done_d;

   logic [SW-1:0]         sum_w [NS];
   logic [ACC_BITS-1:0]   fit_v [NS];
   logic                  smp_load, smp_add;

   logic                  mv_q, mo_q;
   logic [ACC_BITS-1:0]   out_q [NS];
   logic [COUNT_BITS-1:0] ocnt_q;
   logic                  out_ld, out_drop;
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
   logic [NS-1:0]         fit_o;
   logic                  sat_q, sat_d;
   logic                  osat_q;
`endif

   assign gx_w = PW'(s_gradx);
   assign gy_w = PW'(s_grady);
   assign dt_w = PW'(s_diff);

   // Stage P: full-precision products with the frame markers delayed alongside
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pv_q <= 1'b0;
         pf_q <= 1'b0;
         pl_q <= 1'b0;
         for (int i = 0; i < NS; i++) prod_q[i] <= '0;
      end else if (cke) begin
         pv_q      <= s_valid;
         pf_q      <= s_valid && s_first;
         pl_q      <= s_valid && s_last;
         prod_q[0] <= gx_w * gx_w;
         prod_q[1] <= gy_w * gy_w;
         prod_q[2] <= gx_w * gy_w;
         prod_q[3] <= gx_w * dt_w;
         prod_q[4] <= gy_w * dt_w;
      end
   end

   // A first sample always (re)loads; other samples only add inside a frame
   assign smp_load = pv_q && pf_q;
   assign smp_add  = pv_q && !pf_q && (state_q == ST_ACC);

   // Sum in a width that cannot overflow before the final fit to ACC_BITS
   always_comb begin
      for (int i = 0; i < NS; i++) begin
         sum_w[i] = SW'(prod_q[i]);
         if (smp_add)
            sum_w[i] = sum_w[i] + SW'($signed(acc_q[i]));
      end
   end

   // Fit each sum to ACC_BITS: clamp when saturating, else plain wrap
   always_comb begin
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
      fit_o = '0;
      for (int i = 0; i < NS; i++) begin
         fit_o[i] = !((&sum_w[i][SW-1:ACC_BITS-1]) ||
                      !(|sum_w[i][SW-1:ACC_BITS-1]));
         fit_v[i] = sum_w[i][ACC_BITS-1:0];
         if (fit_o[i])
            fit_v[i] = sum_w[i][SW-1] ? SAT_MIN : SAT_MAX;
      end
`else
      for (int i = 0; i < NS; i++) fit_v[i] = sum_w[i];
`endif
   end

   // Frame FSM next state: load/add, count, and flag frame completion
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
      sat_d   = sat_q;
`endif
      if (smp_load || smp_add) begin
         acc_d   = fit_v;
         cnt_d   = smp_load ? COUNT_BITS'(1) : cnt_q + COUNT_BITS'(1);
         state_d = pl_q ? ST_IDLE : ST_ACC;
         done_d  = pl_q;
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
         sat_d   = (smp_load ? 1'b0 : sat_q) | (|fit_o);
`endif
      end
   end

   // Stage A: FSM state, accumulators and counter, all held while cke=0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < NS; i++) acc_q[i] <= '0;
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
         sat_q   <= 1'b0;
`endif
      end else if (cke) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         acc_q   <= acc_d;
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
         sat_q   <= sat_d;
`endif
      end
   end

   // A finished frame loads only if the holding register is free this cycle
   assign out_ld   = cke && done_q && (!mv_q || m.m_ready);
   assign out_drop = cke && done_q && mv_q && !m.m_ready;

   // Output holding register; the handshake keeps running while cke=0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mv_q   <= 1'b0;
         mo_q   <= 1'b0;
         ocnt_q <= '0;
         for (int i = 0; i < NS; i++) out_q[i] <= '0;
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
         osat_q <= 1'b0;
`endif
      end else begin
         mo_q <= out_drop;
         if (out_ld) begin
            mv_q   <= 1'b1;
            out_q  <= acc_q;
            ocnt_q <= cnt_q;
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
            osat_q <= sat_q;
`endif
         end else if (m.m_ready) begin
            mv_q <= 1'b0;
         end
      end
   end

   assign m.m_valid   = mv_q;
   assign m.m_overrun = mo_q;
   assign m.m_gxx     = out_q[0];
   assign m.m_gyy     = out_q[1];
   assign m.m_gxy     = out_q[2];
   assign m.m_ex      = out_q[3];
   assign m.m_ey      = out_q[4];
   assign m.m_count   = ocnt_q;
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
   assign m.m_saturated = osat_q;
`endif

endmodule

// File: tb/tb_img_lk_accumulator.sv
// Scoreboard bench for img_lk_accumulator with directed frames.
// Built with ACC_BITS=16 so the wrap/saturation boundary is reachable.
module tb_img_lk_accumulator;
   localparam int SB = 12;
   localparam int AB = 16;
   localparam int CB = 24;

   typedef struct {
      longint gxx;
      longint gyy;
      longint gxy;
      longint ex;
      longint ey;
      longint cnt;
      longint sat;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 cke;
   logic                 s_valid;
   logic                 s_first;
   logic                 s_last;
   logic signed [SB-1:0] s_diff;
   logic signed [SB-1:0] s_gradx;
   logic signed [SB-1:0] s_grady;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   img_lk_accumulator_if #(.ACC_BITS(AB), .COUNT_BITS(CB)) mif ();

   img_lk_accumulator #(
      .SOBEL_BITS(SB),
      .ACC_BITS  (AB),
      .COUNT_BITS(CB)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .cke    (cke),
      .s_valid(s_valid),
      .s_first(s_first),
      .s_last (s_last),
      .s_diff (s_diff),
      .s_gradx(s_gradx),
      .s_grady(s_grady),
      .m      (mif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input bit f, input bit l,
                       input int gx, input int gy, input int dt);
      s_valid = 1'b1;
      s_first = f;
      s_last  = l;
      s_gradx = SB'(gx);
      s_grady = SB'(gy);
      s_diff  = SB'(dt);
      tick(1);
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_first = 1'b0;
      s_last  = 1'b0;
      tick(n);
   endtask

   task automatic push(input longint gxx, input longint gyy, input longint gxy,
                       input longint ex, input longint ey, input longint cnt,
                       input longint sat);
      exp_t e;
      e.gxx = gxx;
      e.gyy = gyy;
      e.gxy = gxy;
      e.ex  = ex;
      e.ey  = ey;
      e.cnt = cnt;
      e.sat = sat;
      sb_q.push_back(e);
   endtask

   // Monitor: every accepted result is popped and compared
   always @(negedge clk) begin
      if (reset_n && mif.m_valid && mif.m_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got gxx %0d, expected none",
                     mif.m_gxx);
         end else begin
            mon_e = sb_q.pop_front();
            chk("m_gxx", mif.m_gxx, mon_e.gxx);
            chk("m_gyy", mif.m_gyy, mon_e.gyy);
            chk("m_gxy", mif.m_gxy, mon_e.gxy);
            chk("m_ex", mif.m_ex, mon_e.ex);
            chk("m_ey", mif.m_ey, mon_e.ey);
            chk("m_count", mif.m_count, mon_e.cnt);
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
            chk("m_saturated", mif.m_saturated, mon_e.sat);
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b1;
      cke         = 1'b1;
      s_valid     = 1'b0;
      s_first     = 1'b0;
      s_last      = 1'b0;
      s_gradx     = '0;
      s_grady     = '0;
      s_diff      = '0;
      mif.m_ready = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_m_valid", mif.m_valid, 0);
      chk("rst_m_overrun", mif.m_overrun, 0);
      chk("rst_m_gxx", mif.m_gxx, 0);
      chk("rst_m_ey", mif.m_ey, 0);
      chk("rst_m_count", mif.m_count, 0);
      tick(2);
      reset_n = 1'b1;
      tick(1);

      // 4-sample frame, latency of two edges after the last sample
      push(36, 16, -24, 60, -40, 4, 0);
      send(1, 0, 3, -2, 5);
      send(0, 0, 3, -2, 5);
      send(0, 0, 3, -2, 5);
      send(0, 1, 3, -2, 5);
      chk("lat_e0_valid", mif.m_valid, 0);
      idle(1);
      chk("lat_e1_valid", mif.m_valid, 0);
      idle(1);
      chk("lat_e2_valid", mif.m_valid, 1);
      idle(1);
      chk("accepted_clear", mif.m_valid, 0);

      // Samples outside a frame are ignored, then a single-sample frame
      send(0, 0, 100, 50, -30);
      send(0, 1, 1, 1, 1);
      send(0, 0, 5, 5, 5);
      idle(4);
      chk("idle_ignored", mif.m_valid, 0);
      push(49, 1, -7, 14, -2, 1, 0);
      send(1, 1, -7, 1, -2);
      idle(4);

      // Held result A, frame B dropped with an overrun pulse
      mif.m_ready = 1'b0;
      push(1, 4, 2, 3, 6, 1, 0);
      send(1, 1, 1, 2, 3);
      idle(3);
      chk("hold_a_valid", mif.m_valid, 1);
      send(1, 1, 4, 4, 4);
      chk("ovr_e0", mif.m_overrun, 0);
      idle(1);
      chk("ovr_e1", mif.m_overrun, 0);
      idle(1);
      chk("ovr_pulse", mif.m_overrun, 1);
      chk("ovr_keep_gxx", mif.m_gxx, 1);
      chk("ovr_keep_valid", mif.m_valid, 1);
      idle(1);
      chk("ovr_end", mif.m_overrun, 0);
      mif.m_ready = 1'b1;
      idle(1);
      chk("a_accepted", mif.m_valid, 0);

      // Frame C loads in the same cycle A2 is accepted
      mif.m_ready = 1'b0;
      push(4, 9, 6, 2, 3, 1, 0);
      send(1, 1, 2, 3, 1);
      idle(3);
      chk("hold_a2_valid", mif.m_valid, 1);
      push(2, 5, -1, 4, -5, 2, 0);
      send(1, 0, 1, 1, 1);
      send(0, 1, -1, 2, -3);
      idle(1);
      mif.m_ready = 1'b1;
      idle(1);
      chk("b2b_valid", mif.m_valid, 1);
      chk("b2b_no_ovr", mif.m_overrun, 0);
      chk("b2b_gxx", mif.m_gxx, 2);
      idle(1);
      chk("b2b_clear", mif.m_valid, 0);

      // cke gaps: mid-frame and after the last sample
      mif.m_ready = 1'b0;
      push(36, 16, -24, 60, -40, 4, 0);
      send(1, 0, 3, -2, 5);
      cke = 1'b0;
      for (int i = 0; i < 3; i++) send(1, 1, 99, 99, 99);
      cke = 1'b1;
      send(0, 0, 3, -2, 5);
      send(0, 0, 3, -2, 5);
      send(0, 1, 3, -2, 5);
      cke = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("cke_hold_valid", mif.m_valid, 0);
      end
      cke = 1'b1;
      idle(1);
      chk("cke_e1_valid", mif.m_valid, 0);
      idle(1);
      chk("cke_e2_valid", mif.m_valid, 1);
      cke = 1'b0;
      mif.m_ready = 1'b1;
      idle(1);
      chk("cke0_ready_clear", mif.m_valid, 0);
      cke = 1'b1;

      // Restart on a second first marker
      push(6, 10, -1, -1, 2, 3, 0);
      send(1, 0, 9, 9, 9);
      send(1, 0, 1, 0, 2);
      send(0, 0, 2, 1, -1);
      send(0, 1, -1, 3, 1);
      idle(4);

      // Reset mid-frame with a held result pending
      mif.m_ready = 1'b0;
      send(1, 1, 1, 1, 1);
      idle(3);
      chk("pre_rst_valid", mif.m_valid, 1);
      send(1, 0, 2, 2, 2);
      send(0, 0, 2, 2, 2);
      s_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", mif.m_valid, 0);
      chk("mid_rst_gxx", mif.m_gxx, 0);
      chk("mid_rst_count", mif.m_count, 0);
      tick(1);
      reset_n = 1'b1;
      mif.m_ready = 1'b1;
      send(0, 1, 3, 3, 3);
      idle(4);
      chk("post_rst_no_valid", mif.m_valid, 0);
      push(25, 9, -15, 10, -6, 1, 0);
      send(1, 1, 5, -3, 2);
      idle(4);

      // Accumulator boundary: 10 x 2047^2 at ACC_BITS=16
`ifdef IMG_LK_ACCUMULATOR_SATURATE_EN
      push(32767, 0, 0, 0, 0, 10, 1);
`else
      push(24586, 0, 0, 0, 0, 10, 0);
`endif
      for (int i = 0; i < 10; i++) send(i == 0, i == 9, 2047, 0, 0);
      idle(4);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick(1);
      chk("scoreboard_drain", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/img_lk_accumulator.md
Name: img_lk_accumulator

Overview:
Consumer of the Sobel/LK gradient stream (diff, gradx, grady) for the optical-flow pipeline.
- Forms the five Lucas-Kanade products per valid pixel and accumulates them over one frame or ROI, delimited by s_first/s_last.
- Presents the frame sums to the flow solver through a valid/ready holding register.
- The input side is cke-gated streaming with no back-pressure. The output side is a handshake.

Parameters:
SOBEL_BITS, 12, signed width of s_diff/s_gradx/s_grady
ACC_BITS, 48, signed width of each accumulator and output sum
COUNT_BITS, 24, unsigned width of the pixel counter

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
cke  input  1  clock enable for the input pipeline and accumulators
s_valid  input  1  input sample valid
s_first  input  1  first sample of frame (qualified by s_valid)
s_last  input  1  last sample of frame (qualified by s_valid)
s_diff  input  SOBEL_BITS  signed temporal difference It
s_gradx  input  SOBEL_BITS  signed Ix
s_grady  input  SOBEL_BITS  signed Iy
m_valid  output  1  frame sums valid
m_ready  input  1  solver accepts sums
m_gxx  output  ACC_BITS  sum Ix*Ix
m_gyy  output  ACC_BITS  sum Iy*Iy
m_gxy  output  ACC_BITS  sum Ix*Iy
m_ex  output  ACC_BITS  sum Ix*It
m_ey  output  ACC_BITS  sum Iy*It
m_count  output  COUNT_BITS  number of accumulated samples
m_overrun  output  1  one-cycle pulse: a completed frame was dropped

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to ST_IDLE.
  - All pipeline registers, accumulators, counter and outputs go to 0; m_valid=0, m_overrun=0.
  - Reset mid-frame discards the partial frame.
  - Reset while m_valid=1 drops the held result.
- Stage P (cke=1), products registered:
  - 2*SOBEL_BITS signed full-precision products gx*gx, gy*gy, gx*gy, gx*diff, gy*diff.
  - valid, first and last are delayed alongside.
- Stage A (cke=1), accumulate. Products are sign-extended to ACC_BITS. Wrap modulo 2^ACC_BITS (unless the optional feature is enabled); counter wraps modulo 2^COUNT_BITS.
- Sign convention: raw sums only. Negation of the b vector is the solver's job.
- cke=0: stages P and A and the FSM hold. The output handshake (m_valid clear on m_ready) still operates.
- FSM, evaluated on the delayed stage-P sample when cke=1:
  - ST_IDLE: valid and not first -> ignored. valid and first -> accumulators loaded (not added) with the sample's products, count=1, go to ST_ACC.
  - ST_ACC: valid -> add products, count+1. valid and first -> restart: load instead of add, count=1, stay in ST_ACC; the partial frame is silently discarded.
  - Frame end: valid and last (in ST_ACC, or together with first in either state) -> frame ends with this sample included, go to ST_IDLE.
  - first and last on the same sample = single-sample frame, count=1.
- Frame completion:
  - Final sums (including the last sample) are written to the m_* registers and m_valid=1.
  - Latency: m_valid rises 2 enabled clk edges after the edge capturing s_valid&&s_last.
  - Load is allowed only if m_valid=0, or m_valid=1 and m_ready=1 in the same cycle (back-to-back).
  - Otherwise the new frame is dropped, the held result is kept unchanged, and m_overrun pulses for 1 cycle.
- Handshake:
  - m_valid stays 1 and all m_* outputs stay stable until a cycle with m_ready=1.
  - m_valid clears the cycle after acceptance unless a new frame loads in that same cycle.

Optional Feature:
Macro IMG_LK_ACCUMULATOR_SATURATE_EN.
- Defined:
  - Each accumulator saturates at +(2^(ACC_BITS-1)-1) / -(2^(ACC_BITS-1)) instead of wrapping.
  - Extra output m_saturated (1 bit) is set if any accumulator saturated during the frame. It is loaded with the m_* sums and cleared at frame start.
- Undefined: wrap-around arithmetic; the m_saturated port does not exist.

Test Plan:
- Frame of 4 valid samples (first on #0, last on #3), gx=3, gy=-2, diff=5, cke=1 -> m_valid 2 edges after #3; gxx=36, gyy=16, gxy=-24, ex=60, ey=-40, count=4.
- Samples with s_valid=1 and no s_first while in ST_IDLE, then a 1-sample frame (first&last, gx=-7, gy=1, diff=-2) -> gxx=49, gyy=1, gxy=-7, ex=14, ey=-2, count=1; the earlier samples have no effect.
- Frame A completes with m_ready=0 and is held; frame B completes while still held -> m_overrun one-cycle pulse, outputs still show A. Then m_ready=1 -> m_valid=0 next cycle. Frame C completes in the same cycle as A is accepted -> m_valid stays 1 with C's sums.
- Toggle cke=0 for 3 cycles in the middle of the 4-sample frame -> identical sums, m_valid delayed by exactly 3 cycles. m_ready during cke=0 still clears m_valid.
- s_first re-asserted on sample 2 of an unfinished frame, last on sample 4 -> count=3, sums over samples 2..4 only. Separately: reset_n pulsed low mid-frame -> all outputs 0 immediately, no m_valid until the next full frame.
- With the macro defined, ACC_BITS=16, 10 samples gx=2047 -> m_gxx=32767, m_saturated=1. Without the macro -> m_gxx = 10*2047^2 mod 2^16 (as signed).
